// File: rtl/arb_pkg.sv
// Shared types and the rotate-priority search used by the 4-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scans ptr+1, ptr+2, ptr+3, then ptr itself; the last-granted index ends up lowest priority.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] reqVec,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res = '{found: 1'b0, idx: '0};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!res.found && reqVec[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dec2x4_n.sv
// Combinational 2-to-4 decoder with active-low enable and active-low outputs.
module dec2x4_n
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   i_sel,
  input  logic               i_en_n,
  output logic [NUM_REQ-1:0] o_y_n
);

  always_comb begin
    o_y_n = '1;
    if (!i_en_n) begin
      o_y_n[i_sel] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a per-owner hold limit and timeout preemption.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_owner, w_owner;
  logic [IDX_W-1:0] r_ptr, w_ptr;
  logic [7:0]       r_hold, w_hold;
  logic             r_preempt, w_preempt;

  logic [NUM_REQ-1:0] w_ownerMask;
  pick_t              w_pickAll;
  pick_t              w_pickOther;
  logic               w_valid;

  assign w_ownerMask = NUM_REQ'(1) << r_owner;
  assign w_pickAll   = rr_pick(req, r_ptr);
  assign w_pickOther = rr_pick(req & ~w_ownerMask, r_ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_owner   <= w_owner;
      r_ptr     <= w_ptr;
      r_hold    <= w_hold;
      r_preempt <= w_preempt;
    end
  end

  // A dropped request wins over a coincident timeout, so the drop branch is tested first.
  always_comb begin
    w_state   = r_state;
    w_owner   = r_owner;
    w_ptr     = r_ptr;
    w_hold    = r_hold;
    w_preempt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pickAll.found) begin
          w_state = BUSY;
          w_owner = w_pickAll.idx;
          w_ptr   = w_pickAll.idx;
          w_hold  = '0;
        end
      end
      BUSY: begin
        if (!req[r_owner]) begin
          w_hold = '0;
          if (w_pickOther.found) begin
            w_owner = w_pickOther.idx;
            w_ptr   = w_pickOther.idx;
          end else begin
            w_state = IDLE;
          end
        end else if (r_hold == HOLD_LAST) begin
          w_hold = '0;
          if (w_pickOther.found) begin
            w_owner   = w_pickOther.idx;
            w_ptr     = w_pickOther.idx;
            w_preempt = 1'b1;
          end
        end else begin
          w_hold = r_hold + 8'd1;
        end
      end
      default: begin
        w_state = IDLE;
        w_hold  = '0;
      end
    endcase
  end

  always_comb begin
    w_valid   = (r_state == BUSY);
    gnt_valid = w_valid;
    gnt_idx   = w_valid ? r_owner : '0;
    preempt   = r_preempt;
  end

  dec2x4_n u_dec (
    .i_sel  (r_owner),
    .i_en_n (~w_valid),
    .o_y_n  (gnt_n)
  );

endmodule

// File: tb/tb_rr_arb4.sv
// Directed self-checking bench for rr_arb4 with hand-computed grant sequences.
module tb_rr_arb4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int testCount;
  int failCount;

  rr_arb4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then step one rising edge and settle so outputs are sampled away from it.
  task automatic applyStimulus(input logic rst, input logic [3:0] r);
    reset = rst;
    req   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkGrant(input string tag, input logic [1:0] expIdx,
                            input logic expValid, input logic expPre);
    logic [3:0] expN;
    expN = expValid ? ~(4'b0001 << expIdx) : 4'b1111;
    checkOutput({tag, ".gnt_n"},     8'(gnt_n),     8'(expN));
    checkOutput({tag, ".gnt_idx"},   8'(gnt_idx),   8'(expValid ? expIdx : 2'd0));
    checkOutput({tag, ".gnt_valid"}, 8'(gnt_valid), 8'(expValid));
    checkOutput({tag, ".preempt"},   8'(preempt),   8'(expPre));
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    req   = 4'b0000;

    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b1111);
    checkGrant("reset", 2'd0, 1'b0, 1'b0);

    // All four requesting: each owner holds 8 cycles, preempt on every switch after the first.
    applyStimulus(1'b0, 4'b1111);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        checkGrant($sformatf("rot.g%0d.c%0d", g, c), 2'(g % 4), 1'b1, (c == 0) && (g > 0));
        applyStimulus(1'b0, 4'b1111);
      end
    end

    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0100);
    checkGrant("single2.grant", 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000);
    checkGrant("single2.idle", 2'd0, 1'b0, 1'b0);

    // ptr is now 2: grant 1, then 1 drops with 0 and 3 pending -> 3 wins, no bubble.
    applyStimulus(1'b0, 4'b0010);
    checkGrant("drop.own1", 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1001);
    checkGrant("drop.own3", 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000);
    checkGrant("drop.idle", 2'd0, 1'b0, 1'b0);

    // Lone requester across several hold-limit boundaries keeps its grant without preempt.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 4'b0100);
      checkGrant($sformatf("lone2.c%0d", c), 2'd2, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000);
    checkGrant("lone2.idle", 2'd0, 1'b0, 1'b0);

    applyStimulus(1'b0, 4'b1000);
    checkGrant("rst3.grant", 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1000);
    checkGrant("rst3.revoked", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1010);
    checkGrant("rst3.first1", 2'd1, 1'b1, 1'b0);

    // Owner 1 reaches hold count 7 and drops on that same edge while 0 requests.
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, 4'b0010);
      checkGrant($sformatf("tdrop.hold.c%0d", c), 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 4'b0001);
    checkGrant("tdrop.own0", 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0001);
    checkGrant("tdrop.own0.next", 2'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
